ofs_plat_utils_ccip_c0_rd_arbiter: RTL and testbench



---
 rtl/ofs_plat_utils_ccip_c0_rd_arbiter.sv | 112 +++++++++++
 tb/tb_ofs_plat_utils_ccip_c0_rd_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_utils_ccip_c0_rd_arbiter.sv
// Round-robin sharing of one CCI-P c0 read channel by two requesters, with exact outstanding-line credit.
// Grant -> c0Tx one cycle later; c0Rx -> rsp0/rsp1 one cycle later; ready drops on almost-full or lack of line credit.
module ofs_plat_utils_ccip_c0_rd_arbiter #(
    parameter int MAX_ACTIVE_LINES = 512,
    parameter int CNT_WIDTH        = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [73:0]          req0_hdr,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [73:0]          req1_hdr,
    output logic                 req1_ready,
    input  logic                 c0TxAlmFull,
    output logic [74:0]          c0Tx,
    input  logic [542:0]         c0Rx,
    output logic [542:0]         rsp0,
    output logic [542:0]         rsp1,
    output logic [CNT_WIDTH-1:0] active_lines
);

    localparam int                CW1        = CNT_WIDTH + 1;
    localparam logic [CW1-1:0]    LIMIT      = CW1'(MAX_ACTIVE_LINES);
    localparam logic [3:0]        RSP_RDLINE = 4'h0;

    logic [CNT_WIDTH-1:0] r_active;
    logic                 r_last;
    logic [74:0]          r_tx;
    logic [542:0]         r_rsp0;
    logic [542:0]         r_rsp1;

    logic [CNT_WIDTH-1:0] w_len0;
    logic [CNT_WIDTH-1:0] w_len1;
    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_grant;
    logic [73:0]          w_tx_hdr;
    logic [CNT_WIDTH-1:0] w_add;
    logic [CNT_WIDTH-1:0] w_sum;
    logic [CNT_WIDTH-1:0] w_next;
    logic                 w_rd_rsp;
    logic                 w_underflow;
    logic                 w_tag;
    logic [27:0]          w_rx_hdr;

    // cl_len encodes 1, 2 or 4 lines as 0, 1, 3
    assign w_len0 = CNT_WIDTH'(req0_hdr[69:68]) + CNT_WIDTH'(1);
    assign w_len1 = CNT_WIDTH'(req1_hdr[69:68]) + CNT_WIDTH'(1);

    assign w_elig0 = req0_valid && !c0TxAlmFull && (({1'b0, r_active} + {1'b0, w_len0}) <= LIMIT);
    assign w_elig1 = req1_valid && !c0TxAlmFull && (({1'b0, r_active} + {1'b0, w_len1}) <= LIMIT);

    assign w_grant0 = w_elig0 && (!w_elig1 || r_last);
    assign w_grant1 = w_elig1 && (!w_elig0 || !r_last);
    assign w_grant  = w_grant0 || w_grant1;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    always_comb begin
        w_tx_hdr     = w_grant1 ? req1_hdr : req0_hdr;
        w_tx_hdr[15] = w_grant1;
    end

    // Credit returns on the response's arrival cycle, so grant and return net out in one step
    assign w_rd_rsp    = c0Rx[2] && (c0Rx[534:531] == RSP_RDLINE);
    assign w_add       = w_grant0 ? w_len0 : (w_grant1 ? w_len1 : '0);
    assign w_sum       = r_active + w_add;
    assign w_underflow = w_rd_rsp && (w_sum == '0);
    assign w_next      = (w_rd_rsp && !w_underflow) ? (w_sum - CNT_WIDTH'(1)) : w_sum;

    assign w_tag = c0Rx[530];

    always_comb begin
        w_rx_hdr = c0Rx[542:515];
        if (w_rd_rsp) begin
            w_rx_hdr[15] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            r_last   <= 1'b1;
            r_tx     <= '0;
            r_rsp0   <= '0;
            r_rsp1   <= '0;
        end else begin
            r_active <= w_next;
            if (w_grant) begin
                r_last <= w_grant1;
                r_tx   <= {1'b1, w_tx_hdr};
            end else begin
                r_tx[74] <= 1'b0;
            end
            // MMIO and non-read responses always belong to port 0
            r_rsp0 <= {w_rx_hdr, c0Rx[514:3], c0Rx[2] && !(w_rd_rsp && w_tag), c0Rx[1:0]};
            r_rsp1 <= {w_rx_hdr, c0Rx[514:3], w_rd_rsp && w_tag, 2'b00};
            assert (!w_underflow)
                else $warning("read response with no outstanding lines; count held at 0");
        end
    end

    assign c0Tx         = r_tx;
    assign rsp0         = r_rsp0;
    assign rsp1         = r_rsp1;
    assign active_lines = r_active;

endmodule

// File: tb/tb_ofs_plat_utils_ccip_c0_rd_arbiter.sv
// Bench for the c0 read arbiter: directed table, corner sequences and random traffic against a line-count model.
module tb_ofs_plat_utils_ccip_c0_rd_arbiter;

    localparam int MAX = 8;
    localparam int CW  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req1_valid, req0_ready, req1_ready, c0TxAlmFull;
    logic [73:0]   req0_hdr, req1_hdr;
    logic [74:0]   c0Tx;
    logic [542:0]  c0Rx, rsp0, rsp1;
    logic [CW-1:0] active_lines;

    logic [1:0]    cl0, cl1;
    logic [15:0]   md0, md1;
    logic [41:0]   ad0, ad1;
    logic          rx_rspv, rx_mmrd, rx_mmwr;
    logic [3:0]    rx_type;
    logic [15:0]   rx_mdata;
    logic [511:0]  rx_data;

    assign req0_hdr = {4'h0, cl0, 4'h0, 6'h00, ad0, md0};
    assign req1_hdr = {4'h0, cl1, 4'h0, 6'h00, ad1, md1};
    assign c0Rx     = {8'h00, rx_type, rx_mdata, rx_data, rx_rspv, rx_mmrd, rx_mmwr};

    always #5 clk = ~clk;

    ofs_plat_utils_ccip_c0_rd_arbiter #(
        .MAX_ACTIVE_LINES(MAX),
        .CNT_WIDTH       (CW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_hdr    (req0_hdr),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_hdr    (req1_hdr),
        .req1_ready  (req1_ready),
        .c0TxAlmFull (c0TxAlmFull),
        .c0Tx        (c0Tx),
        .c0Rx        (c0Rx),
        .rsp0        (rsp0),
        .rsp1        (rsp1),
        .active_lines(active_lines)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference state: outstanding lines as a plain integer and the last-granted requester
    int m_cnt  = 0;
    int m_last = 1;
    bit obs_r0, obs_r1;

    task automatic rx_idle();
        rx_rspv  = 1'b0;
        rx_mmrd  = 1'b0;
        rx_mmwr  = 1'b0;
        rx_type  = 4'h0;
        rx_mdata = 16'h0000;
        rx_data  = '0;
    endtask

    task automatic rx_rdline(input logic [15:0] mdata);
        rx_idle();
        rx_rspv  = 1'b1;
        rx_mdata = mdata;
        rx_data  = {16{$urandom()}};
    endtask

    task automatic req_set(input bit v0, input logic [1:0] c0, input bit v1, input logic [1:0] c1, input bit af);
        req0_valid  = v0;
        req1_valid  = v1;
        cl0         = c0;
        cl1         = c1;
        c0TxAlmFull = af;
        md0         = 16'($urandom());
        md1         = 16'($urandom());
        ad0         = {10'h0, 32'($urandom())};
        ad1         = {10'h0, 32'($urandom())};
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic cycle();
        int l0, l1, rd;
        bit e0, e1, g0, g1, tag, rdl;
        logic [74:0]  exp_tx;
        logic [27:0]  hdr;
        logic [542:0] e_rsp0, e_rsp1;
        #1;
        l0 = int'(cl0) + 1;
        l1 = int'(cl1) + 1;
        e0 = req0_valid && !c0TxAlmFull && (m_cnt + l0 <= MAX);
        e1 = req1_valid && !c0TxAlmFull && (m_cnt + l1 <= MAX);
        g0 = e0 && (!e1 || m_last == 1);
        g1 = e1 && (!e0 || m_last == 0);
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        chk("req0_ready", {575'b0, req0_ready}, {575'b0, g0});
        chk("req1_ready", {575'b0, req1_ready}, {575'b0, g1});
        exp_tx = '0;
        if (g0) exp_tx = {1'b1, req0_hdr[73:16], 1'b0, req0_hdr[14:0]};
        if (g1) exp_tx = {1'b1, req1_hdr[73:16], 1'b1, req1_hdr[14:0]};
        if (g0 || g1) m_last = g1 ? 1 : 0;
        rdl = rx_rspv && (rx_type == 4'h0);
        tag = rx_mdata[15];
        hdr = {8'h00, rx_type, (rdl ? 1'b0 : rx_mdata[15]), rx_mdata[14:0]};
        e_rsp0 = {hdr, rx_data, rx_rspv && !(rdl && tag), rx_mmrd, rx_mmwr};
        e_rsp1 = {hdr, rx_data, rdl && tag, 2'b00};
        m_cnt = m_cnt + (g0 ? l0 : 0) + (g1 ? l1 : 0);
        rd = rdl ? 1 : 0;
        m_cnt = (m_cnt >= rd) ? m_cnt - rd : 0;
        @(posedge clk);
        #1;
        chk("c0Tx_valid", {575'b0, c0Tx[74]}, {575'b0, exp_tx[74]});
        if (exp_tx[74]) chk("c0Tx", 576'(c0Tx), 576'(exp_tx));
        chk("active_lines", 576'(active_lines), 576'(m_cnt));
        chk("rsp0_valids", 576'(rsp0[2:0]), 576'(e_rsp0[2:0]));
        chk("rsp1_valids", 576'(rsp1[2:0]), 576'(e_rsp1[2:0]));
        if (|e_rsp0[2:0]) chk("rsp0", 576'(rsp0), 576'(e_rsp0));
        if (|e_rsp1[2:0]) chk("rsp1", 576'(rsp1), 576'(e_rsp1));
        @(negedge clk);
    endtask

    typedef struct {
        bit         v0;
        logic [1:0] cl0;
        bit         v1;
        logic [1:0] cl1;
        bit         af;
        bit         rsp;
        bit         r0;
        bit         r1;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pick, r;
        // ---- directed table: v0 cl0 v1 cl1 af rsp | ready0 ready1 count_after
        tbl.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 1});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 1, 2});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 3});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0, 1, 4});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0, 0, 4});
        tbl.push_back('{1, 0, 1, 0, 1, 0, 0, 0, 4});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 5});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 1, 0, 6});
        tbl.push_back('{1, 3, 1, 1, 0, 0, 0, 1, 8});
        tbl.push_back('{1, 3, 0, 0, 0, 1, 0, 0, 7});
        tbl.push_back('{1, 3, 0, 0, 0, 1, 0, 0, 6});
        tbl.push_back('{1, 3, 0, 0, 0, 1, 0, 0, 5});
        tbl.push_back('{1, 3, 0, 0, 0, 1, 0, 0, 4});
        tbl.push_back('{1, 3, 0, 0, 0, 0, 1, 0, 8});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 7});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 6});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 5});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 4});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 3});
        tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 1, 4});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 1, 0, 5});

        // ---- reset state
        reset = 1'b1;
        req_set(0, 0, 0, 0, 0);
        rx_idle();
        @(negedge clk);
        #1;
        chk("rst_c0Tx_valid", 576'(c0Tx[74]), 576'(0));
        chk("rst_rsp0_valids", 576'(rsp0[2:0]), 576'(0));
        chk("rst_rsp1_valids", 576'(rsp1[2:0]), 576'(0));
        chk("rst_active_lines", 576'(active_lines), 576'(0));
        @(negedge clk);
        reset = 1'b0;

        // ---- table
        for (int i = 0; i < tbl.size(); i++) begin
            req_set(tbl[i].v0, tbl[i].cl0, tbl[i].v1, tbl[i].cl1, tbl[i].af);
            if (tbl[i].rsp) rx_rdline({i[0], 15'h0123});
            else rx_idle();
            cycle();
            chk($sformatf("tbl%0d_ready0", i), 576'(obs_r0), 576'(tbl[i].r0));
            chk($sformatf("tbl%0d_ready1", i), 576'(obs_r1), 576'(tbl[i].r1));
            chk($sformatf("tbl%0d_count", i), 576'(active_lines), 576'(tbl[i].cnt));
        end

        // ---- steering by tag, then MMIO to port 0 only
        req_set(0, 0, 0, 0, 0);
        rx_rdline(16'h8005);
        cycle();
        chk("steer_rsp1_valid", 576'(rsp1[2]), 576'(1));
        chk("steer_rsp1_mdata", 576'(rsp1[530:515]), 576'(16'h0005));
        chk("steer_rsp0_valid", 576'(rsp0[2]), 576'(0));
        rx_idle();
        rx_mmrd  = 1'b1;
        rx_mdata = 16'h8001;
        cycle();
        chk("mmio_rsp0_rd", 576'(rsp0[1]), 576'(1));
        chk("mmio_rsp1_rd", 576'(rsp1[1]), 576'(0));

        // ---- asynchronous reset with 7 lines outstanding, then late responses
        for (int k = 0; k < 20 && m_cnt < 7; k++) begin
            req_set(1, 0, 0, 0, 0);
            rx_idle();
            rx_mmrd = 1'b1;
            cycle();
        end
        chk("pre_reset_count", 576'(active_lines), 576'(7));
        req_set(0, 0, 0, 0, 0);
        rx_idle();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_c0Tx_valid", 576'(c0Tx[74]), 576'(0));
        chk("arst_active_lines", 576'(active_lines), 576'(0));
        chk("arst_rsp0_valids", 576'(rsp0[2:0]), 576'(0));
        chk("arst_rsp1_valids", 576'(rsp1[2:0]), 576'(0));
        m_cnt  = 0;
        m_last = 1;
        @(negedge clk);
        reset = 1'b0;
        rx_rdline(16'h8042);
        cycle();
        chk("late_count_a", 576'(active_lines), 576'(0));
        chk("late_rsp1_mdata", 576'(rsp1[530:515]), 576'(16'h0042));
        rx_rdline(16'h0033);
        cycle();
        chk("late_count_b", 576'(active_lines), 576'(0));
        chk("late_rsp0_valid", 576'(rsp0[2]), 576'(1));

        // ---- random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            pick = $urandom_range(0, 2);
            req_set($urandom_range(0, 1), 2'((pick == 2) ? 3 : pick),
                    $urandom_range(0, 1), 2'(($urandom_range(0, 2) == 2) ? 3 : $urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0));
            r = $urandom_range(0, 9);
            rx_idle();
            if (r < 4 && m_cnt > 0) begin
                rx_rdline(16'($urandom()));
            end else if (r == 4) begin
                rx_rdline(16'($urandom()));
                rx_type = 4'h1;
            end else if (r == 5) begin
                rx_mmrd  = 1'b1;
                rx_mdata = 16'($urandom());
            end else if (r == 6) begin
                rx_mmwr = 1'b1;
                rx_data = {16{$urandom()}};
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
